// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage (port 0)
// and the branch/compare unit (port 1). One operation in flight, registered operands and results.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req0_op,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp0_y,
    output logic [WIDTH-1:0] rsp1_y,
    output logic [2:0]       rsp0_flags,
    output logic [2:0]       rsp1_flags,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_lt,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    state_t           state;
    logic             prio;
    logic             owner;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       eligible;
    logic [1:0]       grant;

    // A requester still holding an unconsumed response is kept out of arbitration.
    always_comb begin
        eligible = req_valid & ~rsp_valid;
        grant    = 2'b00;
        if (state == IDLE) begin
            if (eligible == 2'b11) begin
                grant = prio ? 2'b10 : 2'b01;
            end else begin
                grant = eligible;
            end
        end
    end

    assign req_ready  = grant;
    assign alu_opcode = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign busy       = (state == EXEC);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prio       <= 1'b0;
            owner      <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_valid  <= 2'b00;
            rsp0_y     <= '0;
            rsp1_y     <= '0;
            rsp0_flags <= '0;
            rsp1_flags <= '0;
            op_count   <= '0;
        end else begin
            rsp_valid <= rsp_valid & ~rsp_ready;
            case (state)
                IDLE: begin
                    // grant is a subset of req_valid, so any grant bit is a handshake
                    if (grant != 2'b00) begin
                        owner <= grant[1];
                        prio  <= ~grant[1];
                        op_q  <= grant[1] ? req1_op : req0_op;
                        a_q   <= grant[1] ? req1_a  : req0_a;
                        b_q   <= grant[1] ? req1_b  : req0_b;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (owner) begin
                        rsp1_y     <= alu_y;
                        rsp1_flags <= {alu_carry, alu_zero, alu_lt};
                    end else begin
                        rsp0_y     <= alu_y;
                        rsp0_flags <= {alu_carry, alu_zero, alu_lt};
                    end
                    rsp_valid[owner] <= 1'b1;
                    op_count         <= op_count + CNT_W'(1);
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
